heap_access_sequencer: RTL and testbench
========================================

Name: heap_access_sequencer

Overview:
- Initiator-side master for the memory controller's post-boot port. Converts single-beat CPU/evaluator commands (READ, WRITE, CONS) into correctly timed read_enable/write_enable/addr/write_data sequences.
- Owns the cons bump allocator: CONS writes the car and cdr words to consecutive addresses and returns the new cell pointer.
- Sits between the evaluator core and the memory controller.

Parameters:
- ADDR_WIDTH, 16, memory word-address width; matches the controller.
- DATA_WIDTH, 32, memory word width; matches the controller.
- HEAP_BASE, 16'h1000, first cell address after reset; must be even.
- HEAP_LIMIT, 16'hFFFF, last usable heap word address, inclusive.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- boot_done  in  1  memory controller finished ROM copy; no commands accepted while low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  00 READ, 01 WRITE, 10 CONS, 11 reserved
- cmd_addr  in  ADDR_WIDTH  target address for READ/WRITE
- cmd_data_a  in  DATA_WIDTH  WRITE data, or CONS car
- cmd_data_b  in  DATA_WIDTH  CONS cdr
- rsp_valid  out  1  response available; held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_data  out  DATA_WIDTH  READ: word; CONS: zero-extended cell pointer; WRITE: 0
- rsp_error  out  1  command failed; qualified by rsp_valid
- alloc_ptr  out  ADDR_WIDTH  next free cell address
- mem_read_enable  out  1  to controller read_enable
- mem_write_enable  out  1  to controller write_enable
- mem_addr  out  ADDR_WIDTH  to controller addr
- mem_write_data  out  DATA_WIDTH  to controller write_data
- mem_read_data  in  DATA_WIDTH  from controller read_data
- mem_error  in  1  from controller memory_error

Behaviour:
- Reset: rst synchronous, active-high, clock clk. All of the following are reset at any time, including mid-sequence; no memory strobe is issued in the reset cycle or the cycle after:
  - state=IDLE
  - cmd_ready=0, rsp_valid=0, rsp_error=0, rsp_data=0
  - mem_read_enable=0, mem_write_enable=0, mem_addr=0, mem_write_data=0
  - alloc_ptr=HEAP_BASE
- Handshake:
  - cmd_ready = (state==IDLE) && boot_done && !rst.
  - Command fields are captured into registers on acceptance.
- Controller timing (decided contract):
  - The controller latches addr on any cycle where an enable is high.
  - The RAM write uses the address latched in an earlier cycle.
  - Read data is valid 2 cycles after the latch cycle.
  - Consequently every access starts with a LATCH cycle using mem_read_enable=1 (never mem_write_enable, to avoid a write to a stale address).
- States: IDLE, RD_LATCH, RD_WAIT, RD_CAPTURE, WR_LATCH, WR_COMMIT, RESPOND, ERROR_RSP.
- mem_* outputs are combinational from registered state; all strobes are 0 in IDLE, RD_WAIT, RD_CAPTURE, RESPOND and ERROR_RSP.
- READ, accepted in cycle T:
  - T+1 RD_LATCH: mem_read_enable=1, mem_addr=addr.
  - T+2 RD_WAIT: mem_addr held.
  - T+3 RD_CAPTURE: rsp_data<=mem_read_data.
  - T+4 RESPOND: rsp_valid=1.
- WRITE, accepted in cycle T:
  - T+1 WR_LATCH: mem_read_enable=1, mem_addr=addr, mem_write_data=data.
  - T+2 WR_COMMIT: mem_write_enable=1, mem_addr and mem_write_data held.
  - T+3 RESPOND.
- CONS, accepted in cycle T:
  - If alloc_ptr+1 > HEAP_LIMIT (compare at ADDR_WIDTH+1 bits so there is no wrap), go straight to ERROR_RSP: no memory traffic, alloc_ptr unchanged.
  - Otherwise write car at alloc_ptr (WR_LATCH/WR_COMMIT), then cdr at alloc_ptr+1 (second WR_LATCH/WR_COMMIT; a 1-bit word index selects the second word).
  - RESPOND at T+5 with rsp_data=old alloc_ptr.
  - alloc_ptr+=2 in the same cycle RESPOND is entered.
- Reserved op: ERROR_RSP, rsp_data=0.
- mem_error high in any non-IDLE cycle aborts the sequence:
  - Next state is ERROR_RSP and strobes drop immediately.
  - A CONS in flight does not advance alloc_ptr.
- RESPOND / ERROR_RSP:
  - rsp_valid=1; rsp_error=0 in RESPOND, 1 in ERROR_RSP.
  - rsp_data stable until rsp_valid && rsp_ready, then return to IDLE.
  - No new command is accepted in the handshake cycle, so back-to-back commands are spaced by at least 1 IDLE cycle.
- boot_done falling while busy: the current command completes normally. boot_done is only checked at acceptance.

Test Plan:
- Boot gating: boot_done=0, cmd_valid=1 for 20 cycles -> cmd_ready=0, no mem strobes. Raise boot_done -> accepted next cycle.
- Write then read: WRITE addr 0x0040, data 0xDEADBEEF, then READ 0x0040 -> mem_write_enable exactly 1 cycle, with mem_addr=0x0040 and latch cycle before it. READ rsp_valid at T+4 with rsp_data=0xDEADBEEF, rsp_error=0.
- CONS pair: two CONS (car 1, cdr 2) and (car 3, cdr 4) from reset -> rsp_data 0x1000 then 0x1002, alloc_ptr=0x1004. READs of 0x1000..0x1003 return 1, 2, 3, 4.
- Heap full: HEAP_LIMIT=0x1003, third CONS -> rsp_error=1, zero mem strobes, alloc_ptr stays 0x1004.
- Backpressure and errors:
  - rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0.
  - mem_error pulsed in WR_COMMIT of a CONS -> ERROR_RSP, alloc_ptr unchanged.
- Reset mid-CONS: rst asserted in the cdr WR_LATCH cycle -> next cycle all outputs 0, alloc_ptr=HEAP_BASE, no further write strobes.

Source files
------------

// File: rtl/heap_access_sequencer_if.sv
// rtl/heap_access_sequencer_if.sv - command/response and memory-controller signal bundle for the heap access sequencer
interface heap_access_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data_a;
    logic [DATA_WIDTH-1:0] cmd_data_b;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_error;

    logic                  mem_read_enable;
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  mem_error;

    // Evaluator core plus memory controller side
    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data_a, cmd_data_b, rsp_ready,
        output mem_read_data, mem_error,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error,
        input  mem_read_enable, mem_write_enable, mem_addr, mem_write_data
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data_a, cmd_data_b, rsp_ready,
        input  mem_read_data, mem_error,
        output cmd_ready, rsp_valid, rsp_data, rsp_error,
        output mem_read_enable, mem_write_enable, mem_addr, mem_write_data
    );
endinterface

// File: rtl/heap_access_sequencer.sv
// rtl/heap_access_sequencer.sv - sequences READ/WRITE/CONS commands onto the memory controller post-boot port
module heap_access_sequencer #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] HEAP_BASE  = 16'h1000,
    parameter logic [ADDR_WIDTH-1:0] HEAP_LIMIT = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  boot_done,
    output logic [ADDR_WIDTH-1:0] alloc_ptr,
    heap_access_sequencer_if.slave bus
);
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CONS  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_LATCH,
        RD_WAIT,
        RD_CAPTURE,
        WR_LATCH,
        WR_COMMIT,
        RESPOND,
        ERROR_RSP
    } state_t;

    state_t                state;
    state_t                state_d;
    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_a_q;
    logic [DATA_WIDTH-1:0] data_b_q;
    logic                  word_idx;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    logic                  accept;
    logic                  in_access;
    logic                  heap_full;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    // One extra bit so a pointer at the top of the address space cannot wrap past the limit
    assign heap_full = ({1'b0, alloc_ptr} + {{ADDR_WIDTH{1'b0}}, 1'b1}) > {1'b0, HEAP_LIMIT};
    assign wr_addr   = addr_q + {{(ADDR_WIDTH-1){1'b0}}, word_idx};
    assign wr_data   = word_idx ? data_b_q : data_a_q;
    assign in_access = (state == RD_LATCH) || (state == RD_WAIT) || (state == RD_CAPTURE) ||
                       (state == WR_LATCH) || (state == WR_COMMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d       = state;
        accept        = 1'b0;
        bus.cmd_ready = (state == IDLE) && boot_done && !rst;
        case (state)
            IDLE: begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    accept = 1'b1;
                    case (bus.cmd_op)
                        OP_READ:  state_d = RD_LATCH;
                        OP_WRITE: state_d = WR_LATCH;
                        OP_CONS:  state_d = heap_full ? ERROR_RSP : WR_LATCH;
                        default:  state_d = ERROR_RSP;
                    endcase
                end
            end
            RD_LATCH:   state_d = RD_WAIT;
            RD_WAIT:    state_d = RD_CAPTURE;
            RD_CAPTURE: state_d = RESPOND;
            WR_LATCH:   state_d = WR_COMMIT;
            WR_COMMIT:  state_d = (op_q == OP_CONS && !word_idx) ? WR_LATCH : RESPOND;
            RESPOND,
            ERROR_RSP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default:    state_d = IDLE;
        endcase
        if (in_access && bus.mem_error) begin
            state_d = ERROR_RSP;
        end
    end

    // Every access opens with a read-enable latch cycle so the controller never writes to a stale address
    always_comb begin
        bus.mem_read_enable  = 1'b0;
        bus.mem_write_enable = 1'b0;
        bus.mem_addr         = '0;
        bus.mem_write_data   = '0;
        case (state)
            RD_LATCH: begin
                bus.mem_read_enable = 1'b1;
                bus.mem_addr        = addr_q;
            end
            RD_WAIT,
            RD_CAPTURE: begin
                bus.mem_addr = addr_q;
            end
            WR_LATCH: begin
                bus.mem_read_enable = 1'b1;
                bus.mem_addr        = wr_addr;
                bus.mem_write_data  = wr_data;
            end
            WR_COMMIT: begin
                bus.mem_write_enable = 1'b1;
                bus.mem_addr         = wr_addr;
                bus.mem_write_data   = wr_data;
            end
            default: ;
        endcase
        if (rst || bus.mem_error) begin
            bus.mem_read_enable  = 1'b0;
            bus.mem_write_enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_READ;
            addr_q     <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            word_idx   <= 1'b0;
            rsp_data_q <= '0;
            alloc_ptr  <= HEAP_BASE;
        end else begin
            if (accept) begin
                op_q       <= bus.cmd_op;
                addr_q     <= (bus.cmd_op == OP_CONS) ? alloc_ptr : bus.cmd_addr;
                data_a_q   <= bus.cmd_data_a;
                data_b_q   <= bus.cmd_data_b;
                word_idx   <= 1'b0;
                rsp_data_q <= '0;
            end
            if (state == WR_COMMIT && state_d == WR_LATCH) begin
                word_idx <= 1'b1;
            end
            if (state == RD_CAPTURE && state_d == RESPOND) begin
                rsp_data_q <= bus.mem_read_data;
            end
            // The pointer only moves once both cell words have committed without error
            if (state == WR_COMMIT && state_d == RESPOND && op_q == OP_CONS) begin
                rsp_data_q <= DATA_WIDTH'(addr_q);
                alloc_ptr  <= alloc_ptr + ADDR_WIDTH'(2);
            end
        end
    end

    assign bus.rsp_valid = ((state == RESPOND) || (state == ERROR_RSP)) && !rst;
    assign bus.rsp_error = (state == ERROR_RSP) && !rst;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_heap_access_sequencer.sv
// tb/tb_heap_access_sequencer.sv - scoreboard bench for heap_access_sequencer with a controller model
module tb_heap_access_sequencer;
    localparam logic [15:0] HEAP_BASE  = 16'h1000;
    localparam logic [15:0] HEAP_LIMIT = 16'h1003;

    logic clk;
    logic rst;
    logic boot_done;
    logic [15:0] alloc_ptr;

    heap_access_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dif ();

    heap_access_sequencer #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(32),
        .HEAP_BASE (HEAP_BASE),
        .HEAP_LIMIT(HEAP_LIMIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .boot_done(boot_done),
        .alloc_ptr(alloc_ptr),
        .bus      (dif)
    );

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } sb_entry_t;

    sb_entry_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_cnt = 0;
    int first_cyc = 0;
    logic rsp_prev = 1'b0;
    int re_cnt = 0;
    int we_cnt = 0;
    logic [15:0] we_addr = '0;
    logic [31:0] we_data = '0;
    logic latch_ok = 1'b0;
    logic prev_re = 1'b0;
    logic [15:0] prev_addr = '0;
    logic err_arm = 1'b0;
    int waited;

    logic [31:0] mem [int unsigned];
    logic [15:0] lat_addr = '0;
    logic [31:0] rd_p1 = '0;
    logic [31:0] rd_p2 = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller: latch on any enable, write to the earlier latched address, read data two cycles after latch
    always @(posedge clk) begin
        if (dif.mem_write_enable) mem[lat_addr] = dif.mem_write_data;
        if (dif.mem_read_enable || dif.mem_write_enable) lat_addr <= dif.mem_addr;
        rd_p1 <= mem_rd(dif.mem_addr);
        rd_p2 <= rd_p1;
    end
    assign dif.mem_read_data = rd_p2;

    always @(posedge clk) begin
        #1;
        if (dif.mem_error) dif.mem_error = 1'b0;
        else if (err_arm && dif.mem_write_enable) begin
            dif.mem_error = 1'b1;
            err_arm = 1'b0;
        end
    end

    always @(negedge clk) begin
        sb_entry_t e;
        if (dif.rsp_valid && !rsp_prev) first_cyc = cyc;
        rsp_prev = dif.rsp_valid;
        if (dif.rsp_valid && dif.rsp_ready) begin
            if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'(1));
            else begin
                e = sb.pop_front();
                check({e.tag, "_data"}, 64'(dif.rsp_data), 64'(e.data));
                check({e.tag, "_err"}, 64'(dif.rsp_error), 64'(e.err));
                check({e.tag, "_lat"}, 64'(first_cyc - e.acc), 64'(e.lat));
            end
            resp_cnt++;
        end
        if (dif.mem_read_enable) re_cnt++;
        if (dif.mem_write_enable) begin
            we_cnt++;
            we_addr = dif.mem_addr;
            we_data = dif.mem_write_data;
            latch_ok = prev_re && (prev_addr == dif.mem_addr);
        end
        prev_re = dif.mem_read_enable;
        prev_addr = dif.mem_addr;
    end

    task automatic check_idle(input string tag);
        check({tag, "_cmd_ready"}, 64'(dif.cmd_ready), 64'(0));
        check({tag, "_rsp_valid"}, 64'(dif.rsp_valid), 64'(0));
        check({tag, "_rsp_error"}, 64'(dif.rsp_error), 64'(0));
        check({tag, "_rsp_data"}, 64'(dif.rsp_data), 64'(0));
        check({tag, "_re"}, 64'(dif.mem_read_enable), 64'(0));
        check({tag, "_we"}, 64'(dif.mem_write_enable), 64'(0));
        check({tag, "_mem_addr"}, 64'(dif.mem_addr), 64'(0));
        check({tag, "_mem_wdata"}, 64'(dif.mem_write_data), 64'(0));
        check({tag, "_alloc_ptr"}, 64'(alloc_ptr), 64'(HEAP_BASE));
    endtask

    task automatic send(input string tag, input logic [1:0] op, input logic [15:0] addr,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_d,
                        input logic exp_e, input int lat, input int hold, output int nwait);
        sb_entry_t e;
        int n;
        int target;
        @(posedge clk); #1;
        dif.cmd_valid = 1'b1;
        dif.cmd_op = op;
        dif.cmd_addr = addr;
        dif.cmd_data_a = a;
        dif.cmd_data_b = b;
        dif.rsp_ready = (hold == 0);
        #1;
        n = 0;
        while (!dif.cmd_ready && n < 50) begin @(posedge clk); #2; n++; end
        nwait = n;
        if (!dif.cmd_ready) begin
            check({tag, "_accept_timeout"}, 64'(n), 64'(0));
            dif.cmd_valid = 1'b0;
            return;
        end
        e.tag = tag; e.data = exp_d; e.err = exp_e; e.lat = lat; e.acc = cyc;
        target = resp_cnt + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        dif.cmd_valid = 1'b0;
        if (hold > 0) begin
            n = 0;
            while (!dif.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
            for (int i = 0; i < hold; i++) begin
                check({tag, "_hold_valid"}, 64'(dif.rsp_valid), 64'(1));
                check({tag, "_hold_data"}, 64'(dif.rsp_data), 64'(exp_d));
                check({tag, "_hold_cmd_ready"}, 64'(dif.cmd_ready), 64'(0));
                @(posedge clk); #1;
            end
            dif.rsp_ready = 1'b1;
        end
        n = 0;
        while (resp_cnt < target && n < 50) begin @(posedge clk); #1; n++; end
        if (resp_cnt < target) check({tag, "_rsp_timeout"}, 64'(resp_cnt), 64'(target));
    endtask

    initial begin
        logic [31:0] cells [4];
        int ready_seen;
        cells[0] = 32'd1; cells[1] = 32'd2; cells[2] = 32'd3; cells[3] = 32'd4;
        rst = 1'b1; boot_done = 1'b0;
        dif.cmd_valid = 1'b0; dif.cmd_op = 2'b00; dif.cmd_addr = '0;
        dif.cmd_data_a = '0; dif.cmd_data_b = '0; dif.rsp_ready = 1'b1; dif.mem_error = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        re_cnt = 0; we_cnt = 0; ready_seen = 0;
        dif.cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (dif.cmd_ready) ready_seen++;
        end
        check("boot_gate_ready", 64'(ready_seen), 64'(0));
        check("boot_gate_strobes", 64'(re_cnt + we_cnt), 64'(0));
        dif.cmd_valid = 1'b0;
        boot_done = 1'b1;
        send("boot_read", 2'b00, 16'h0000, 32'h0, 32'h0, 32'h0, 1'b0, 4, 0, waited);
        check("boot_accept_wait", 64'(waited), 64'(0));

        re_cnt = 0; we_cnt = 0;
        send("write", 2'b01, 16'h0040, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 3, 0, waited);
        check("write_we_cycles", 64'(we_cnt), 64'(1));
        check("write_re_cycles", 64'(re_cnt), 64'(1));
        check("write_we_addr", 64'(we_addr), 64'h0040);
        check("write_we_data", 64'(we_data), 64'hDEADBEEF);
        check("write_latch_before", 64'(latch_ok), 64'(1));
        send("read40", 2'b00, 16'h0040, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 4, 0, waited);

        send("cons0", 2'b10, 16'h0, 32'd1, 32'd2, 32'h1000, 1'b0, 5, 0, waited);
        send("cons1", 2'b10, 16'h0, 32'd3, 32'd4, 32'h1002, 1'b0, 5, 0, waited);
        check("cons_alloc_ptr", 64'(alloc_ptr), 64'h1004);
        for (int i = 0; i < 4; i++)
            send($sformatf("cell_rd%0d", i), 2'b00, 16'h1000 + 16'(i), 32'h0, 32'h0, cells[i], 1'b0, 4, 0, waited);

        re_cnt = 0; we_cnt = 0;
        send("heap_full", 2'b10, 16'h0, 32'd5, 32'd6, 32'h0, 1'b1, 1, 0, waited);
        check("heap_full_strobes", 64'(re_cnt + we_cnt), 64'(0));
        check("heap_full_alloc_ptr", 64'(alloc_ptr), 64'h1004);

        send("reserved", 2'b11, 16'h0040, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, waited);
        send("backpressure", 2'b00, 16'h0040, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 4, 5, waited);

        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("rst_alloc_ptr", 64'(alloc_ptr), 64'(HEAP_BASE));
        err_arm = 1'b1;
        send("cons_memerr", 2'b10, 16'h0, 32'd11, 32'd12, 32'h0, 1'b1, 3, 0, waited);
        check("memerr_alloc_ptr", 64'(alloc_ptr), 64'(HEAP_BASE));

        @(posedge clk); #1;
        dif.cmd_valid = 1'b1; dif.cmd_op = 2'b10; dif.cmd_data_a = 32'd7; dif.cmd_data_b = 32'd8;
        #1;
        check("midrst_ready", 64'(dif.cmd_ready), 64'(1));
        @(posedge clk); #1; dif.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        re_cnt = 0; we_cnt = 0; rst = 1'b1;
        @(posedge clk); #1;
        check_idle("midrst");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_strobes", 64'(re_cnt + we_cnt), 64'(0));
        send("midrst_car", 2'b00, 16'h1000, 32'h0, 32'h0, 32'd7, 1'b0, 4, 0, waited);
        send("midrst_cdr", 2'b00, 16'h1001, 32'h0, 32'h0, 32'd2, 1'b0, 4, 0, waited);
        send("cons_after_rst", 2'b10, 16'h0, 32'd9, 32'd10, 32'h1000, 1'b0, 5, 0, waited);
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
